// File: rtl/pic_prio_ctrl.sv
// pic_prio_ctrl -- sequential, parametrised priority interrupt controller.
//
// Requests from the peripheral lines are latched into a pending register and
// filtered by a software-writable mask. Arbitration uses fixed priority:
// the lower the index, the higher the priority. Nested in-service interrupts
// are tracked in isr. An interrupt is presented only if it outranks
// everything already in service.
//
// Optional feature macro: PIC_NMI_EN adds a non-maskable interrupt path
// (nmi / nmi_ack / nmi_o). This path bypasses the mask, the isr and the FSM.
//
// Ports:
//   clk         system clock, all state on the rising edge
//   rst         asynchronous, active-high reset
//   int_req     raw interrupt request lines (synchronous to clk)
//   mask_we     mask register write strobe
//   mask_wdata  new mask value (1 = masked)
//   int_ack     CPU accepts the interrupt currently presented
//   eoi         CPU end-of-interrupt pulse (retires highest-priority isr bit)
//   mask        current mask register
//   pending     current pending register
//   isr         in-service register
//   int_o       registered interrupt request to the CPU
//   int_id      registered index of the presented source
//   nmi         (PIC_NMI_EN) non-maskable request, rising-edge triggered
//   nmi_ack     (PIC_NMI_EN) CPU acknowledge for nmi_o
//   nmi_o       (PIC_NMI_EN) registered non-maskable interrupt to the CPU
//
// CPU handshake: int_o is the valid and int_ack is the ready. While int_o is
// high, int_o and int_id stay frozen until a cycle with int_ack high. On that
// edge the source moves from pending to isr and int_o drops. At least one
// idle cycle always separates two presentations. int_ack is ignored while
// int_o is low. The FSM state can be observed on int_o, which is high exactly
// when the FSM is in REQ.
module pic_prio_ctrl #(
    parameter int                 NUM_SRC   = 8,
    parameter int                 ID_W      = 3,
    parameter logic [NUM_SRC-1:0] TRIG_EDGE = {NUM_SRC{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] int_req,
    input  logic               mask_we,
    input  logic [NUM_SRC-1:0] mask_wdata,
    input  logic               int_ack,
    input  logic               eoi,
    output logic [NUM_SRC-1:0] mask,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] isr,
    output logic               int_o,
    output logic [ID_W-1:0]    int_id
`ifdef PIC_NMI_EN
    ,
    input  logic               nmi,
    input  logic               nmi_ack,
    output logic               nmi_o
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] mask_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] isr_q, isr_d;
    logic               int_o_q, int_o_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] set_vec;
    logic [NUM_SRC-1:0] ack_vec;
    logic [NUM_SRC-1:0] eoi_vec;
    logic [ID_W-1:0]    win_idx;
    logic [ID_W-1:0]    isr_idx;
    logic               win_valid;
    logic               ack_fire;

    // Index of the lowest set bit. Returns 0 for an all-zero vector, so
    // callers must qualify the result themselves.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [NUM_SRC-1:0] v);
        lowest_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest_idx = ID_W'(i);
        end
    endfunction

    assign eligible  = pending_q & ~mask_q;
    assign win_idx   = lowest_idx(eligible);
    assign isr_idx   = lowest_idx(isr_q);
    // A winner preempts only if it strictly outranks the highest in-service bit.
    assign win_valid = (|eligible) && ((isr_q == '0) || (win_idx < isr_idx));

    assign ack_fire  = (state_q == REQ) && int_ack;
    assign ack_vec   = ack_fire ? (NUM_SRC'(1) << int_id_q) : '0;
    // Isolate the lowest set bit of isr. This is zero when isr is empty,
    // so an eoi with nothing in service does nothing.
    assign eoi_vec   = eoi ? (isr_q & (~isr_q + NUM_SRC'(1))) : '0;

    // Trigger detection. A level source counts as in service from its ack
    // cycle onward. Without this, a line still held high would re-pend on
    // the ack edge, and it would stay pending even after the line dropped
    // before the eoi.
    always_comb begin
        set_vec = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (TRIG_EDGE[i]) set_vec[i] = int_req[i] & ~req_q[i];
            else              set_vec[i] = int_req[i] & ~isr_q[i] & ~ack_vec[i];
        end
    end

    // A set in the same cycle as the ack-clear wins. For isr, the eoi clear
    // is applied to the old value before the ack sets the new bit.
    assign pending_d = (pending_q & ~ack_vec) | set_vec;
    assign isr_d     = (isr_q & ~eoi_vec) | ack_vec;

    always_comb begin
        state_d  = state_q;
        int_o_d  = int_o_q;
        int_id_d = int_id_q;
        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    state_d  = REQ;
                    int_o_d  = 1'b1;
                    int_id_d = win_idx;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = IDLE;
                    int_o_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                int_o_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            mask_q    <= '1;
            pending_q <= '0;
            isr_q     <= '0;
            int_o_q   <= 1'b0;
            int_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= int_req;
            if (mask_we) mask_q <= mask_wdata;
            pending_q <= pending_d;
            isr_q     <= isr_d;
            int_o_q   <= int_o_d;
            int_id_q  <= int_id_d;
        end
    end

    assign mask    = mask_q;
    assign pending = pending_q;
    assign isr     = isr_q;
    assign int_o   = int_o_q;
    assign int_id  = int_id_q;

`ifdef PIC_NMI_EN
    logic nmi_q;
    logic nmi_o_q;

    // A fresh edge that coincides with nmi_ack keeps nmi_o set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_q   <= 1'b0;
            nmi_o_q <= 1'b0;
        end else begin
            nmi_q   <= nmi;
            nmi_o_q <= (nmi & ~nmi_q) | (nmi_o_q & ~nmi_ack);
        end
    end

    assign nmi_o = nmi_o_q;
`else
    // No non-maskable path in this build.
`endif

endmodule

// File: tb/tb_pic_prio_ctrl.sv
module tb_pic_prio_ctrl;

  localparam int NSRC = 8;
  localparam logic [NSRC-1:0] TRIG = 8'hEF;  // source 4 is level-triggered

  logic            clk;
  logic            rst;
  logic [NSRC-1:0] int_req;
  logic            mask_we;
  logic [NSRC-1:0] mask_wdata;
  logic            int_ack;
  logic            eoi;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] pending;
  logic [NSRC-1:0] isr;
  logic            int_o;
  logic [2:0]      int_id;
`ifdef PIC_NMI_EN
  logic            nmi;
  logic            nmi_ack;
  logic            nmi_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [NSRC-1:0] m_mask, m_pending, m_isr, m_req_q;
  logic            m_int_o;
  int              m_int_id;
`ifdef PIC_NMI_EN
  logic            m_nmi_q, m_nmi_o;
`endif

  pic_prio_ctrl #(
    .NUM_SRC  (NSRC),
    .ID_W     (3),
    .TRIG_EDGE(TRIG)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .int_req   (int_req),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .mask      (mask),
    .pending   (pending),
    .isr       (isr),
    .int_o     (int_o),
    .int_id    (int_id)
`ifdef PIC_NMI_EN
    ,
    .nmi       (nmi),
    .nmi_ack   (nmi_ack),
    .nmi_o     (nmi_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mask    = '1;
    m_pending = '0;
    m_isr     = '0;
    m_req_q   = '0;
    m_int_o   = 1'b0;
    m_int_id  = 0;
`ifdef PIC_NMI_EN
    m_nmi_q   = 1'b0;
    m_nmi_o   = 1'b0;
`endif
  endtask

  // One clock edge of the controller, computed from the behavioural rules.
  task automatic model_step();
    logic [NSRC-1:0] new_p, new_i;
    int ack_src, lo_isr, win;
    ack_src = (m_int_o && int_ack) ? m_int_id : -1;
    new_i = m_isr;
    if (eoi) begin
      for (int i = 0; i < NSRC; i++) begin
        if (m_isr[i]) begin
          new_i[i] = 1'b0;
          break;
        end
      end
    end
    if (ack_src >= 0) new_i[ack_src] = 1'b1;
    new_p = m_pending;
    if (ack_src >= 0) new_p[ack_src] = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (TRIG[i]) begin
        if (int_req[i] && !m_req_q[i]) new_p[i] = 1'b1;
      end else begin
        if (int_req[i] && !m_isr[i] && i != ack_src) new_p[i] = 1'b1;
      end
    end
    lo_isr = NSRC;
    for (int i = 0; i < NSRC; i++) begin
      if (m_isr[i]) begin
        lo_isr = i;
        break;
      end
    end
    win = -1;
    for (int i = 0; i < NSRC; i++) begin
      if (m_pending[i] && !m_mask[i]) begin
        win = i;
        break;
      end
    end
    if (m_int_o) begin
      if (int_ack) m_int_o = 1'b0;
    end else if (win >= 0 && win < lo_isr) begin
      m_int_o  = 1'b1;
      m_int_id = win;
    end
    m_pending = new_p;
    m_isr     = new_i;
    if (mask_we) m_mask = mask_wdata;
    m_req_q   = int_req;
`ifdef PIC_NMI_EN
    m_nmi_o = (nmi && !m_nmi_q) || (m_nmi_o && !nmi_ack);
    m_nmi_q = nmi;
`endif
  endtask

  task automatic check_all();
    check("mask", mask, m_mask);
    check("pending", pending, m_pending);
    check("isr", isr, m_isr);
    check("int_o", int_o, m_int_o);
    check("int_id", int_id, m_int_id);
`ifdef PIC_NMI_EN
    check("nmi_o", nmi_o, m_nmi_o);
`endif
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Asserts reset between edges and checks that it acts without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    check("rst_int_o", int_o, 0);
    check("rst_mask", mask, 8'hFF);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; int_req = '0; mask_we = 1'b0; mask_wdata = '0; int_ack = 1'b0; eoi = 1'b0;
`ifdef PIC_NMI_EN
    nmi = 1'b0; nmi_ack = 1'b0;
`endif
    do_reset();

    // basic edge request, two-cycle latency, ack
    mask_we = 1'b1; mask_wdata = 8'hFB; step(); mask_we = 1'b0;
    int_req = 8'h04; step();
    check("tp1_pend", pending, 8'h04);
    check("tp1_no_int_yet", int_o, 0);
    int_req = 8'h00; step();
    check("tp1_int_o", int_o, 1);
    check("tp1_id", int_id, 2);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("tp1_isr", isr, 8'h04);
    check("tp1_pend_clr", pending, 8'h00);
    check("tp1_int_o_drop", int_o, 0);

    // nesting: lower priority waits, higher priority preempts
    mask_we = 1'b1; mask_wdata = 8'h00; step(); mask_we = 1'b0;
    int_req = 8'h20; step(); int_req = 8'h00; step(); step();
    check("tp2_pend5", pending, 8'h20);
    check("tp2_blocked5", int_o, 0);
    int_req = 8'h01; step(); int_req = 8'h00; step();
    check("tp2_int0", int_o, 1);
    check("tp2_id0", int_id, 0);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("tp2_isr05", isr, 8'h05);
    eoi = 1'b1; step(); eoi = 1'b0;
    check("tp2_isr04", isr, 8'h04);
    repeat (3) begin
      step();
      check("tp2_still_blocked", int_o, 0);
    end
    eoi = 1'b1; step(); eoi = 1'b0;
    check("tp2_isr_empty", isr, 8'h00);
    step();
    check("tp2_int5", int_o, 1);
    check("tp2_id5", int_id, 5);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    eoi = 1'b1; step(); eoi = 1'b0;

    // REQ holds frozen against a higher-priority arrival
    int_req = 8'h08; step(); int_req = 8'h00; step();
    check("tp3_id3", int_id, 3);
    int_req = 8'h02; step(); int_req = 8'h00; step(); step();
    check("tp3_frozen_id", int_id, 3);
    check("tp3_frozen_o", int_o, 1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("tp3_idle_gap", int_o, 0);
    step();
    check("tp3_int1", int_o, 1);
    check("tp3_id1", int_id, 1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("tp3_isr0a", isr, 8'h0A);
    eoi = 1'b1; step(); step(); eoi = 1'b0;

    // simultaneous ack and eoi
    int_req = 8'h02; step(); int_req = 8'h00; step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    int_req = 8'h01; step(); int_req = 8'h00; step();
    check("tp5_id0", int_id, 0);
    int_ack = 1'b1; eoi = 1'b1; step(); int_ack = 1'b0; eoi = 1'b0;
    check("tp5_isr01", isr, 8'h01);
    eoi = 1'b1; step(); eoi = 1'b0;

    // level source 4 held high re-pends after eoi
    int_req = 8'h10; step(); step();
    check("tp4_id4", int_id, 4);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    check("tp4_pend_clr", pending, 8'h00);
    repeat (3) step();
    check("tp4_no_repend", pending, 8'h00);
    eoi = 1'b1; step(); eoi = 1'b0;
    step();
    check("tp4_repend", pending, 8'h10);
    check("tp4_not_yet", int_o, 0);
    step();
    check("tp4_represent", int_o, 1);
    check("tp4_represent_id", int_id, 4);
    int_ack = 1'b1; step(); int_ack = 1'b0; int_req = 8'h00;
    step();
    eoi = 1'b1; step(); eoi = 1'b0;
    repeat (4) step();
    check("tp4_dropped_o", int_o, 0);
    check("tp4_dropped_p", pending, 8'h00);

`ifdef PIC_NMI_EN
    int_req = 8'h40; step(); int_req = 8'h00; step();
    nmi = 1'b1; step(); nmi = 1'b0;
    check("nmi_set", nmi_o, 1);
    check("nmi_int_o_kept", int_o, 1);
    check("nmi_id_kept", int_id, 6);
    nmi_ack = 1'b1; step(); nmi_ack = 1'b0;
    check("nmi_cleared", nmi_o, 0);
    nmi = 1'b1; step();
`endif

    // asynchronous reset in the middle of REQ
    int_req = 8'h04; step(); int_req = 8'h00; step();
    check("rstreq_int_o", int_o, 1);
    #3;
    do_reset();

    // randomized phase
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NSRC; i++) int_req[i] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) int_req[4] = m_req_q[4];
      int_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 5) == 0);
      mask_we = ($urandom_range(0, 19) == 0);
      mask_wdata = NSRC'($urandom_range(0, 255));
`ifdef PIC_NMI_EN
      nmi     = ($urandom_range(0, 9) == 0);
      nmi_ack = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
